// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run controller: gates a slow clock into one-cycle CPU enables,
// with synchronized board inputs, a debounced step button and a HALT/RUN/STEP FSM.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   slow_clock_in,
  input  logic                   step_button_n,
  input  logic                   run_switch,
  input  logic                   halt_req,
  output logic                   step_pulse,
  output logic [COUNT_WIDTH-1:0] step_count,
  output logic                   running,
  output logic                   halted
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

  logic slow_s1_q, slow_s2_q, btn_s1_q, btn_s2_q, run_s1_q, run_s2_q;
  logic [1:0] settle_q, settle_d;
  logic settled;
  logic slow_prev_q, slow_prev_d, run_prev_q, run_prev_d;
  logic slow_rise, run_rise, slow_edge_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic btn_acc_q, btn_acc_d, press_q, press_d;
  state_e state_q, state_d;
  logic step_pulse_q, step_pulse_d;
  logic [COUNT_WIDTH-1:0] step_count_q, step_count_d;

  // Synchronizer outputs read as zero for two cycles after reset; edge detectors and the
  // debouncer ignore them until the chains hold real input values.
  assign settled = (settle_q == 2'd2);

  always_comb begin
    settle_d    = settled ? settle_q : settle_q + 2'd1;
    slow_prev_d = settled ? slow_s2_q : 1'b1;
    run_prev_d  = settled ? run_s2_q : 1'b1;
    slow_rise   = settled & slow_s2_q & ~slow_prev_q;
    run_rise    = settled & run_s2_q & ~run_prev_q;
  end

  always_comb begin
    db_cnt_d  = '0;
    btn_acc_d = btn_acc_q;
    press_d   = 1'b0;
    if (settled && (btn_s2_q != btn_acc_q)) begin
      if (db_cnt_q == DbMax) begin
        btn_acc_d = btn_s2_q;
        press_d   = ~btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    step_pulse_d = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (run_rise) begin
          state_d = StRun;
        end else if (press_q) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (halt_req || !run_s2_q) begin
          state_d = StHalt;
        end else if (slow_edge_q) begin
          step_pulse_d = 1'b1;
        end
      end
      StStep: begin
        if (slow_edge_q) begin
          step_pulse_d = 1'b1;
          state_d      = StHalt;
        end
      end
      default: state_d = StHalt;
    endcase
    step_count_d = step_pulse_d ? step_count_q + COUNT_WIDTH'(1) : step_count_q;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      slow_s1_q    <= 1'b0;
      slow_s2_q    <= 1'b0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      run_s1_q     <= 1'b0;
      run_s2_q     <= 1'b0;
      settle_q     <= 2'd0;
      slow_prev_q  <= 1'b1;
      run_prev_q   <= 1'b1;
      slow_edge_q  <= 1'b0;
      db_cnt_q     <= '0;
      btn_acc_q    <= 1'b1;
      press_q      <= 1'b0;
      state_q      <= StHalt;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      slow_s1_q    <= slow_clock_in;
      slow_s2_q    <= slow_s1_q;
      btn_s1_q     <= step_button_n;
      btn_s2_q     <= btn_s1_q;
      run_s1_q     <= run_switch;
      run_s2_q     <= run_s1_q;
      settle_q     <= settle_d;
      slow_prev_q  <= slow_prev_d;
      run_prev_q   <= run_prev_d;
      slow_edge_q  <= slow_rise;
      db_cnt_q     <= db_cnt_d;
      btn_acc_q    <= btn_acc_d;
      press_q      <= press_d;
      state_q      <= state_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;
  assign running    = (state_q == StRun);
  assign halted     = (state_q == StHalt);

endmodule
